// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory-access stage: bus widths, RV32 load/store
// opcodes and access-size encodings, plus the stage FSM state type.
package mem_stage_pkg;
    localparam int INSTBUS_W = 32;
    localparam int REGBUS_W  = 32;
    localparam int DBUS_W    = 32;
    localparam int REGADDR_W = 5;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // funct3[1:0] encodes the access size; funct3[2] marks unsigned loads
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;
endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering for the load/store unit: store byte enables and lane
// replication, load extraction with sign/zero extension, misalignment flag.
module mem_stage_lsu_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        off_i,
    input  logic [REGBUS_W-1:0] st_data_i,
    input  logic [DBUS_W-1:0] rdata_i,
    output logic [3:0]        be_o,
    output logic [DBUS_W-1:0] wdata_o,
    output logic [REGBUS_W-1:0] ld_data_o,
    output logic              misalign_o
);
    logic [DBUS_W-1:0] shifted_s;

    assign shifted_s = rdata_i >> {off_i, 3'b000};

    // Size decode drives enables, replicated write data and extended read data
    always_comb begin
        be_o       = 4'b0000;
        wdata_o    = 32'h0000_0000;
        ld_data_o  = 32'h0000_0000;
        misalign_o = 1'b0;
        case (funct3_i[1:0])
            SIZE_B: begin
                be_o      = 4'b0001 << off_i;
                wdata_o   = {4{st_data_i[7:0]}};
                ld_data_o = {{24{shifted_s[7] & ~funct3_i[2]}}, shifted_s[7:0]};
            end
            SIZE_H: begin
                misalign_o = off_i[0];
                be_o       = 4'b0011 << off_i;
                wdata_o    = {2{st_data_i[15:0]}};
                ld_data_o  = {{16{shifted_s[15] & ~funct3_i[2]}}, shifted_s[15:0]};
            end
            default: begin
                misalign_o = (off_i != 2'b00);
                be_o       = 4'b1111;
                wdata_o    = st_data_i;
                ld_data_o  = rdata_i;
            end
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: forwards ALU results to write-back in one cycle
// and runs loads/stores as a req/ack data-bus transaction with timeout.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 ex_valid_i,
    input  logic [INSTBUS_W-1:0] inst_i,
    input  logic [INSTBUS_W-1:0] inst_addr_i,
    input  logic                 reg_w_ena_i,
    input  logic [REGADDR_W-1:0] reg_waddr_i,
    input  logic [REGBUS_W-1:0]  reg_w_data_i,
    input  logic [DBUS_W-1:0]    mem_addr_i,
    input  logic [REGBUS_W-1:0]  mem_wdata_i,
    output logic                 dbus_req_o,
    output logic                 dbus_we_o,
    output logic [DBUS_W-1:0]    dbus_addr_o,
    output logic [DBUS_W-1:0]    dbus_wdata_o,
    output logic [3:0]           dbus_be_o,
    input  logic                 dbus_ack_i,
    input  logic [DBUS_W-1:0]    dbus_rdata_i,
    output logic                 wb_valid_o,
    output logic                 wb_reg_w_ena_o,
    output logic [REGADDR_W-1:0] wb_reg_waddr_o,
    output logic [REGBUS_W-1:0]  wb_reg_wdata_o,
    output logic                 hold_flag_o,
    output logic                 misalign_o,
    output logic [INSTBUS_W-1:0] misalign_pc_o,
    output logic                 bus_err_o
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  req_q, req_d, we_q, we_d;
    logic [DBUS_W-1:0]     addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            off_q, off_d;
    logic [REGADDR_W-1:0]  rd_q, rd_d;
    logic                  ld_wena_q, ld_wena_d;
    logic                  wb_valid_q, wb_valid_d, wb_wena_q, wb_wena_d;
    logic [REGADDR_W-1:0]  wb_waddr_q, wb_waddr_d;
    logic [REGBUS_W-1:0]   wb_wdata_q, wb_wdata_d;
    logic                  mis_q, mis_d, bus_err_q, bus_err_d;
    logic [INSTBUS_W-1:0]  mis_pc_q, mis_pc_d;

    logic                  busy_s, is_load_s, is_store_s, mem_op_s, cnt_last_s;
    logic [2:0]            al_f3_s;
    logic [1:0]            al_off_s;
    logic [3:0]            al_be_s;
    logic [DBUS_W-1:0]     al_wdata_s;
    logic [REGBUS_W-1:0]   al_ld_s;
    logic                  al_mis_s;
    logic                  unused_s;

    assign busy_s     = (state_q == ST_BUSY);
    assign is_load_s  = (inst_i[6:0] == OPC_LOAD);
    assign is_store_s = (inst_i[6:0] == OPC_STORE);
    assign mem_op_s   = is_load_s | is_store_s;
    assign cnt_last_s = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign unused_s   = ^{inst_i[31:15], inst_i[11:7]};

    // While busy the aligner sees the latched access so it can extract load data
    assign al_f3_s  = busy_s ? f3_q  : inst_i[14:12];
    assign al_off_s = busy_s ? off_q : mem_addr_i[1:0];

    mem_stage_lsu_align u_align (
        .funct3_i   (al_f3_s),
        .off_i      (al_off_s),
        .st_data_i  (mem_wdata_i),
        .rdata_i    (dbus_rdata_i),
        .be_o       (al_be_s),
        .wdata_o    (al_wdata_s),
        .ld_data_o  (al_ld_s),
        .misalign_o (al_mis_s)
    );

    // The stall must drop in the final timeout cycle so ex does not replay the access
    assign hold_flag_o = busy_s ? ~(dbus_ack_i | cnt_last_s)
                                : (ex_valid_i & mem_op_s & ~al_mis_s);

    // Next-state and next-output computation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        f3_d       = f3_q;
        off_d      = off_q;
        rd_d       = rd_q;
        ld_wena_d  = ld_wena_q;
        wb_valid_d = 1'b0;
        wb_wena_d  = wb_wena_q;
        wb_waddr_d = wb_waddr_q;
        wb_wdata_d = wb_wdata_q;
        mis_d      = 1'b0;
        mis_pc_d   = mis_pc_q;
        bus_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ex_valid_i && !mem_op_s) begin
                    wb_valid_d = 1'b1;
                    wb_wena_d  = reg_w_ena_i & (reg_waddr_i != 5'd0);
                    wb_waddr_d = reg_waddr_i;
                    wb_wdata_d = reg_w_data_i;
                end else if (ex_valid_i && al_mis_s) begin
                    wb_valid_d = 1'b1;
                    wb_wena_d  = 1'b0;
                    wb_waddr_d = reg_waddr_i;
                    wb_wdata_d = 32'h0000_0000;
                    mis_d      = 1'b1;
                    mis_pc_d   = inst_addr_i;
                end else if (ex_valid_i) begin
                    state_d   = ST_BUSY;
                    cnt_d     = CNT_W'(0);
                    req_d     = 1'b1;
                    we_d      = is_store_s;
                    addr_d    = {mem_addr_i[31:2], 2'b00};
                    be_d      = is_store_s ? al_be_s : 4'b0000;
                    wdata_d   = is_store_s ? al_wdata_s : 32'h0000_0000;
                    f3_d      = inst_i[14:12];
                    off_d     = mem_addr_i[1:0];
                    rd_d      = reg_waddr_i;
                    ld_wena_d = is_load_s & reg_w_ena_i & (reg_waddr_i != 5'd0);
                end else begin
                    wb_valid_d = 1'b0;
                end
            end
            ST_BUSY: begin
                if (dbus_ack_i || cnt_last_s) begin
                    state_d    = ST_IDLE;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    addr_d     = 32'h0000_0000;
                    wdata_d    = 32'h0000_0000;
                    be_d       = 4'b0000;
                    wb_valid_d = 1'b1;
                    wb_waddr_d = rd_q;
                    wb_wena_d  = dbus_ack_i & ld_wena_q;
                    wb_wdata_d = (dbus_ack_i && !we_q) ? al_ld_s : 32'h0000_0000;
                    bus_err_d  = ~dbus_ack_i;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_W'(0);
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0000_0000;
            wdata_q    <= 32'h0000_0000;
            be_q       <= 4'b0000;
            f3_q       <= 3'b000;
            off_q      <= 2'b00;
            rd_q       <= 5'd0;
            ld_wena_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_wena_q  <= 1'b0;
            wb_waddr_q <= 5'd0;
            wb_wdata_q <= 32'h0000_0000;
            mis_q      <= 1'b0;
            mis_pc_q   <= 32'h0000_0000;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
            rd_q       <= rd_d;
            ld_wena_q  <= ld_wena_d;
            wb_valid_q <= wb_valid_d;
            wb_wena_q  <= wb_wena_d;
            wb_waddr_q <= wb_waddr_d;
            wb_wdata_q <= wb_wdata_d;
            mis_q      <= mis_d;
            mis_pc_q   <= mis_pc_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign dbus_req_o     = req_q;
    assign dbus_we_o      = we_q;
    assign dbus_addr_o    = addr_q;
    assign dbus_wdata_o   = wdata_q;
    assign dbus_be_o      = be_q;
    assign wb_valid_o     = wb_valid_q;
    assign wb_reg_w_ena_o = wb_wena_q;
    assign wb_reg_waddr_o = wb_waddr_q;
    assign wb_reg_wdata_o = wb_wdata_q;
    assign misalign_o     = mis_q;
    assign misalign_pc_o  = mis_pc_q;
    assign bus_err_o      = bus_err_q;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a transaction-level model predicts every
// output each cycle, and directed vectors pin hand-computed results.
module tb_mem_stage;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        ex_valid_i = 1'b0;
    logic [31:0] inst_i = 32'h0, inst_addr_i = 32'h0;
    logic        reg_w_ena_i = 1'b0;
    logic [4:0]  reg_waddr_i = 5'd0;
    logic [31:0] reg_w_data_i = 32'h0, mem_addr_i = 32'h0, mem_wdata_i = 32'h0;
    logic        dbus_ack_i = 1'b0;
    logic [31:0] dbus_rdata_i = 32'h0;
    logic        dbus_req_o, dbus_we_o, wb_valid_o, wb_reg_w_ena_o, hold_flag_o;
    logic        misalign_o, bus_err_o;
    logic [31:0] dbus_addr_o, dbus_wdata_o, wb_reg_wdata_o, misalign_pc_o;
    logic [3:0]  dbus_be_o;
    logic [4:0]  wb_reg_waddr_o;

    mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .arst_n(arst_n), .ex_valid_i(ex_valid_i), .inst_i(inst_i),
        .inst_addr_i(inst_addr_i), .reg_w_ena_i(reg_w_ena_i), .reg_waddr_i(reg_waddr_i),
        .reg_w_data_i(reg_w_data_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_wdata_o(dbus_wdata_o), .dbus_be_o(dbus_be_o), .dbus_ack_i(dbus_ack_i),
        .dbus_rdata_i(dbus_rdata_i), .wb_valid_o(wb_valid_o), .wb_reg_w_ena_o(wb_reg_w_ena_o),
        .wb_reg_waddr_o(wb_reg_waddr_o), .wb_reg_wdata_o(wb_reg_wdata_o),
        .hold_flag_o(hold_flag_o), .misalign_o(misalign_o), .misalign_pc_o(misalign_pc_o),
        .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int hold_seen = 0, req_seen = 0;
    logic [31:0] snap_addr = 32'h0, snap_wdata = 32'h0;
    logic [3:0]  snap_be = 4'h0;
    logic        snap_we = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        else if (f3[1:0] == 2'b01) return 2;
        else return 4;
    endfunction

    function automatic logic is_mem(input logic [31:0] inst);
        return (inst[6:0] == 7'b0000011) || (inst[6:0] == 7'b0100011);
    endfunction

    function automatic logic misal(input logic [31:0] inst, input logic [31:0] a);
        return (int'(a[1:0]) % size_of(inst[14:12])) != 0;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rd);
        int sz;
        logic [31:0] v, mask;
        sz = size_of(f3);
        if (sz == 4) return rd;
        v = rd >> (8 * off);
        mask = (32'd1 << (8 * sz)) - 32'd1;
        v = v & mask;
        if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        int sz;
        logic [3:0] m;
        sz = size_of(f3);
        m = (sz == 4) ? 4'hF : ((sz == 2) ? 4'h3 : 4'h1);
        return m << off;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
        int sz;
        sz = size_of(f3);
        if (sz == 1) return (d & 32'h0000_00FF) * 32'h0101_0101;
        if (sz == 2) return (d & 32'h0000_FFFF) * 32'h0001_0001;
        return d;
    endfunction

    // Transaction-level model state and predicted registered outputs
    logic        m_busy = 1'b0, m_st = 1'b0, m_wen = 1'b0;
    int          m_wait = 0;
    logic [31:0] m_addr = 32'h0, m_sdata = 32'h0;
    logic [2:0]  m_f3 = 3'b0;
    logic [4:0]  m_rd = 5'd0;
    logic        m_wbv = 1'b0, m_wbe = 1'b0, m_mis = 1'b0, m_berr = 1'b0;
    logic [4:0]  m_wba = 5'd0;
    logic [31:0] m_wbd = 32'h0, m_mpc = 32'h0;

    initial forever begin
        @(posedge clk or negedge arst_n);
        if (!arst_n) begin
            m_busy = 1'b0; m_wait = 0; m_wbv = 1'b0; m_wbe = 1'b0; m_wba = 5'd0;
            m_wbd = 32'h0; m_mis = 1'b0; m_mpc = 32'h0; m_berr = 1'b0;
        end else begin
            m_wbv = 1'b0; m_mis = 1'b0; m_berr = 1'b0;
            if (m_busy) begin
                m_wait++;
                if (dbus_ack_i) begin
                    m_busy = 1'b0; m_wbv = 1'b1; m_wbe = m_wen; m_wba = m_rd;
                    if (!m_st) m_wbd = load_val(m_f3, m_addr[1:0], dbus_rdata_i);
                end else if (m_wait == TO) begin
                    m_busy = 1'b0; m_berr = 1'b1; m_wbv = 1'b1; m_wbe = 1'b0; m_wba = m_rd;
                end
            end else if (ex_valid_i) begin
                if (!is_mem(inst_i)) begin
                    m_wbv = 1'b1; m_wbe = reg_w_ena_i && (reg_waddr_i != 5'd0);
                    m_wba = reg_waddr_i; m_wbd = reg_w_data_i;
                end else if (misal(inst_i, mem_addr_i)) begin
                    m_wbv = 1'b1; m_wbe = 1'b0; m_wba = reg_waddr_i; m_mis = 1'b1; m_mpc = inst_addr_i;
                end else begin
                    m_busy = 1'b1; m_wait = 0; m_st = (inst_i[6:0] == 7'b0100011);
                    m_addr = mem_addr_i; m_f3 = inst_i[14:12]; m_rd = reg_waddr_i;
                    m_wen = !m_st && reg_w_ena_i && (reg_waddr_i != 5'd0); m_sdata = mem_wdata_i;
                end
            end
        end
    end

    // Per-cycle comparison against the model, mid-way between clock edges
    initial forever begin
        logic exp_hold;
        @(negedge clk);
        #2;
        exp_hold = arst_n && ((!m_busy && ex_valid_i && is_mem(inst_i) && !misal(inst_i, mem_addr_i))
                              || (m_busy && !dbus_ack_i && (m_wait + 1) < TO));
        chk("hold", hold_flag_o, exp_hold);
        chk("req", dbus_req_o, m_busy);
        chk("wb_valid", wb_valid_o, m_wbv);
        chk("wb_wena", wb_reg_w_ena_o, m_wbe);
        if (m_wbe || !arst_n) begin
            chk("wb_waddr", wb_reg_waddr_o, m_wba);
            chk("wb_wdata", wb_reg_wdata_o, m_wbd);
        end
        chk("misalign", misalign_o, m_mis);
        chk("misalign_pc", misalign_pc_o, m_mpc);
        chk("bus_err", bus_err_o, m_berr);
        if (m_busy) begin
            chk("dbus_we", dbus_we_o, m_st);
            chk("dbus_addr", dbus_addr_o, m_addr & 32'hFFFF_FFFC);
            chk("dbus_be", dbus_be_o, m_st ? store_be(m_f3, m_addr[1:0]) : 4'b0000);
            if (m_st) chk("dbus_wdata", dbus_wdata_o, store_wdata(m_f3, m_sdata));
        end
        if (!arst_n) begin
            chk("rst_bus", {dbus_we_o, dbus_be_o, 27'h0}, 32'h0);
            chk("rst_addr", dbus_addr_o, 32'h0);
            chk("rst_wdata", dbus_wdata_o, 32'h0);
        end
        if (hold_flag_o) hold_seen++;
        if (dbus_req_o) begin
            req_seen++;
            snap_addr = dbus_addr_o; snap_wdata = dbus_wdata_o; snap_be = dbus_be_o; snap_we = dbus_we_o;
        end
    end

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [31:0] pc);
        inst_i = {17'h0, f3, rd, opc};
        reg_waddr_i = rd; reg_w_ena_i = 1'b1; reg_w_data_i = alu;
        mem_addr_i = addr; mem_wdata_i = sdata; inst_addr_i = pc;
        ex_valid_i = 1'b1;
        hold_seen = 0; req_seen = 0;
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic [31:0] data, input logic [31:0] pc);
        @(negedge clk);
        drive(7'b0110011, 3'b000, rd, data, 32'h0, 32'h0, pc);
        @(negedge clk);
        ex_valid_i = 1'b0;
        #3;
    endtask

    // ack_at = BUSY cycle (1-based) carrying the ack; 0 means never ack
    task automatic mem_op(input logic st, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] rdata, input int ack_at, input logic [31:0] pc);
        @(negedge clk);
        drive(st ? 7'b0100011 : 7'b0000011, f3, rd, 32'hDEAD_0000, addr, sdata, pc);
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            dbus_ack_i = (k == ack_at);
            dbus_rdata_i = (k == ack_at) ? rdata : 32'h5A5A_5A5A;
            if (k == ack_at) break;
        end
        @(negedge clk);
        dbus_ack_i = 1'b0; ex_valid_i = 1'b0;
        #3;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #3;
        chk("rst_req_lit", dbus_req_o, 1'b0);
        chk("rst_wbv_lit", wb_valid_o, 1'b0);
        @(negedge clk);
        arst_n = 1'b1;

        alu_op(5'd5, 32'h1234_5678, 32'h0000_0010);
        chk("add_valid", wb_valid_o, 1'b1);
        chk("add_waddr", wb_reg_waddr_o, 5'd5);
        chk("add_wdata", wb_reg_wdata_o, 32'h1234_5678);
        chk("add_hold", hold_seen, 0);
        alu_op(5'd0, 32'hFFFF_0000, 32'h0000_0014);
        chk("x0_wena", wb_reg_w_ena_o, 1'b0);

        mem_op(1'b0, 3'b000, 5'd6, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 3, 32'h20);
        chk("lb_addr", snap_addr, 32'h0000_0100);
        chk("lb_be", snap_be, 4'b0000);
        chk("lb_hold", hold_seen, 3);
        chk("lb_wdata", wb_reg_wdata_o, 32'hFFFF_FF80);
        chk("lb_model", m_wbd, 32'hFFFF_FF80);
        mem_op(1'b0, 3'b100, 5'd6, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 3, 32'h24);
        chk("lbu_wdata", wb_reg_wdata_o, 32'h0000_0080);

        mem_op(1'b1, 3'b001, 5'd7, 32'h0000_0202, 32'h0000_BEEF, 32'h0, 1, 32'h28);
        chk("sh_be", snap_be, 4'b1100);
        chk("sh_wdata", snap_wdata, 32'hBEEF_BEEF);
        chk("sh_we", snap_we, 1'b1);
        chk("sh_valid", wb_valid_o, 1'b1);
        chk("sh_wena", wb_reg_w_ena_o, 1'b0);

        mem_op(1'b0, 3'b001, 5'd8, 32'h0000_0102, 32'h0, 32'h80AA_BBCC, 2, 32'h2C);
        chk("lh_wdata", wb_reg_wdata_o, 32'hFFFF_80AA);
        mem_op(1'b0, 3'b101, 5'd8, 32'h0000_0100, 32'h0, 32'h80AA_BBCC, 1, 32'h30);
        chk("lhu_wdata", wb_reg_wdata_o, 32'h0000_BBCC);
        mem_op(1'b0, 3'b010, 5'd0, 32'h0000_0104, 32'h0, 32'h1122_3344, 2, 32'h34);
        chk("lw_x0_wena", wb_reg_w_ena_o, 1'b0);
        chk("lw_x0_req", req_seen, 2);
        mem_op(1'b1, 3'b000, 5'd9, 32'h0000_0001, 32'h1234_5678, 32'h0, 2, 32'h38);
        chk("sb_be", snap_be, 4'b0010);
        chk("sb_wdata", snap_wdata, 32'h7878_7878);
        mem_op(1'b1, 3'b010, 5'd9, 32'h0000_010C, 32'hA1B2_C3D4, 32'h0, 1, 32'h3C);
        chk("sw_be", snap_be, 4'b1111);

        @(negedge clk);
        drive(7'b0000011, 3'b010, 5'd10, 32'h0, 32'h0000_0301, 32'h0, 32'h0000_0400);
        @(negedge clk);
        ex_valid_i = 1'b0;
        #3;
        chk("mis_pulse", misalign_o, 1'b1);
        chk("mis_pc", misalign_pc_o, 32'h0000_0400);
        chk("mis_wena", wb_reg_w_ena_o, 1'b0);
        chk("mis_noreq", req_seen, 0);
        chk("mis_nohold", hold_seen, 0);

        mem_op(1'b0, 3'b010, 5'd11, 32'h0000_0600, 32'h0, 32'h0, 0, 32'h44);
        chk("to_err", bus_err_o, 1'b1);
        chk("to_req_cycles", req_seen, 16);
        chk("to_hold_cycles", hold_seen, 16);
        chk("to_wena", wb_reg_w_ena_o, 1'b0);
        chk("to_req_drop", dbus_req_o, 1'b0);
        mem_op(1'b0, 3'b010, 5'd11, 32'h0000_0600, 32'h0, 32'hCAFE_F00D, 16, 32'h48);
        chk("ack16_err", bus_err_o, 1'b0);
        chk("ack16_wdata", wb_reg_wdata_o, 32'hCAFE_F00D);
        chk("ack16_wena", wb_reg_w_ena_o, 1'b1);

        @(negedge clk);
        drive(7'b0000011, 3'b010, 5'd12, 32'h0, 32'h0000_0700, 32'h0, 32'h0000_004C);
        repeat (2) @(negedge clk);
        #4;
        arst_n = 1'b0; ex_valid_i = 1'b0;
        #1;
        chk("arst_req", dbus_req_o, 1'b0);
        chk("arst_hold", hold_flag_o, 1'b0);
        chk("arst_wbv", wb_valid_o, 1'b0);
        chk("arst_wdata", wb_reg_wdata_o, 32'h0);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);
        alu_op(5'd3, 32'hA5A5_A5A5, 32'h0000_0050);
        chk("post_rst_valid", wb_valid_o, 1'b1);
        chk("post_rst_wdata", wb_reg_wdata_o, 32'hA5A5_A5A5);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access pipeline stage between ex and wb in the RISC_V_PIPE core. It accepts one instruction per cycle from ex and forwards ALU results to wb with 1-cycle latency. Loads and stores run as a req/ack transaction on the data bus with variable latency; the stage stalls upstream via hold_flag_o while a transaction is outstanding. It also performs byte-lane steering, sign/zero extension, misalignment detection and bus timeout.

Parameters:
TIMEOUT_CYCLES, 16, number of BUSY cycles without dbus_ack_i before a bus error is raised (min 2)

Ports:
clk  in  1  core clock, rising edge
arst_n  in  1  asynchronous active-low reset
ex_valid_i  in  1  ex presents a valid instruction this cycle
inst_i  in  32  instruction; opcode [6:0], funct3 [14:12]
inst_addr_i  in  32  PC of instruction
reg_w_ena_i  in  1  write-back enable from ex
reg_waddr_i  in  5  destination register
reg_w_data_i  in  32  ALU result (non-memory ops)
mem_addr_i  in  32  effective address for load/store
mem_wdata_i  in  32  store data (rs2)
dbus_req_o  out  1  bus request, held until ack
dbus_we_o  out  1  1=store, 0=load
dbus_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
dbus_wdata_o  out  32  lane-replicated store data
dbus_be_o  out  4  byte enables (stores; 4'b0000 for loads)
dbus_ack_i  in  1  one-cycle completion strobe; rdata valid with it
dbus_rdata_i  in  32  load data word
wb_valid_o  out  1  result valid to wb (1-cycle pulse per instruction)
wb_reg_w_ena_o  out  1  register write enable to wb
wb_reg_waddr_o  out  5  destination register to wb
wb_reg_wdata_o  out  32  write data to wb
hold_flag_o  out  1  stall request to ctrl
misalign_o  out  1  1-cycle pulse: misaligned access, carries no bus traffic
misalign_pc_o  out  32  PC of the misaligned instruction, held until next misalign
bus_err_o  out  1  1-cycle pulse: bus timeout

Behaviour:
- Reset: state IDLE. All outputs 0, timeout counter 0. Reset mid-transaction drops dbus_req_o immediately and no wb_valid_o is produced.
- Decode: load = opcode 7'b0000011 (funct3 LB 000, LH 001, LW 010, LBU 100, LHU 101); store = 7'b0100011 (SB 000, SH 001, SW 010); everything else is a non-memory op.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0. No bus request. misalign_o pulses next cycle and misalign_pc_o is captured. wb_valid_o=1 with wb_reg_w_ena_o=0.
- IDLE, ex_valid_i, non-memory op: next cycle wb_valid_o=1 and wb fields = inputs. Write enable is forced to 0 when reg_waddr_i==0. No hold.
- IDLE, ex_valid_i, aligned memory op: hold_flag_o=1 combinationally in the same cycle. Operands are latched. Next cycle state is BUSY.
- BUSY: dbus_req_o and all dbus_* outputs are registered and stable until ack. ex_valid_i is ignored. hold_flag_o = !dbus_ack_i.
- Ack cycle: the result is latched and state returns to IDLE. wb_valid_o=1 the following cycle. The next instruction is accepted in that following cycle, so a back-to-back load has a 1-cycle bubble.
- Load data: off=addr[1:0]. LB/LBU take rdata[8*off+7 : 8*off]; LH/LHU take rdata[8*off+15 : 8*off], off in {0,2}. Sign- or zero-extend to 32 bits. LW passes the word through. A load to x0 still issues the bus request; write enable is 0.
- Store lanes: SB be=4'b0001<<off, wdata={4{b}}. SH be=4'b0011<<off, wdata={2{h}}. SW be=4'b1111. wb_valid_o pulses with wb_reg_w_ena_o=0.
- Timeout: the counter clears on entry to BUSY and increments each BUSY cycle without ack. At TIMEOUT_CYCLES: drop req, bus_err_o pulse, wb_valid_o with w_ena=0, return to IDLE, hold deasserted. An ack in the same cycle as timeout wins; no error is raised.
- wb_valid_o, misalign_o and bus_err_o are single-cycle pulses. The wb_* data fields hold their last value when wb_valid_o=0.

Decomposition:
- Shared defines header (existing `define style): opcode and funct3 constants, INSTBUS/REGBUS widths, DBUS width.
- Sub-module lsu_align (combinational): inputs funct3, addr[1:0], store data, rdata. Outputs be, lane-replicated wdata, extended load data and misalign flag. mem_stage holds the FSM, timeout counter and output registers.

Test Plan:
- ADD result 0x1234_5678 to x5, ex_valid_i=1 → next cycle wb_valid_o=1, waddr=5, wdata=0x1234_5678, hold_flag_o never 1.
- LB addr 0x103, ack after 3 cycles with rdata 0x80AA_BBCC → dbus_addr_o=0x100, hold high 3 cycles, wb_reg_wdata_o=0xFFFF_FF80. LBU of the same access → 0x0000_0080.
- SH addr 0x202 data 0x0000_BEEF, ack after 1 cycle → be=4'b1100, wdata=0xBEEF_BEEF, we=1, wb_valid_o=1 with w_ena=0.
- LW addr 0x301 → no dbus_req_o, misalign_o pulse, misalign_pc_o=inst_addr_i, wb w_ena=0.
- LW with no ack (TIMEOUT_CYCLES=16) → req drops after 16 BUSY cycles, bus_err_o pulse, hold released. Repeat with ack on cycle 16 → normal load completes, no error.
- Assert arst_n low during BUSY → req, hold and all outputs go 0 immediately. After release, an ADD completes normally in 1 cycle.
